// File: rtl/uart_tx_pkg.sv
// Shared encodings and line levels for the UART transmit framer and its parity helper.
// Holds no logic, so it adds no latency and has no backpressure of its own.
package uart_tx_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = IDLE,
    S_START  = START,
    S_DATA   = DATA,
    S_PARITY = PARITY,
    S_STOP   = STOP
  } state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

endpackage

// File: rtl/uart_tx_parity.sv
// Parity bit for a data word: even or odd by type.
// Purely combinational, zero latency; no handshake, so no backpressure.
module uart_tx_parity
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  typ_i,
  output logic                  par_o
);

  assign par_o = (^data_i) ^ (typ_i == PAR_ODD);

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start, LSB-first data, optional parity, 1-2 stop bits on a registered line.
// Line changes one CLK after accept or tick; host must wait for Busy=0, requests while busy are dropped.
module uart_tx_framer
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Baud_Tick,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_out,
  output logic                  Busy,
  output logic                  Done
);

  localparam int             CW        = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    par_en_q, par_en_d;
  logic                    par_q, par_d;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    par_calc;

  uart_tx_parity #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .data_i(P_DATA),
    .typ_i (PAR_TYP),
    .par_o (par_calc)
  );

  // tx_d is the level of the state being entered, so the line register
  // always shows the bit currently on the wire.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    par_en_d = par_en_q;
    par_d    = par_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d   = IDLE_LVL;
        busy_d = 1'b0;
        if (Data_Valid) begin
          state_d  = S_START;
          shift_d  = P_DATA;
          par_en_d = PAR_EN;
          par_d    = par_calc;
          cnt_d    = '0;
          busy_d   = 1'b1;
          tx_d     = START_LVL;
        end
      end
      S_START: begin
        if (Baud_Tick) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (Baud_Tick) begin
          shift_d = shift_q >> 1;
          if (cnt_q == DATA_LAST) begin
            cnt_d = '0;
            if (par_en_q) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = STOP_LVL;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
            tx_d  = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (Baud_Tick) begin
          state_d = S_STOP;
          cnt_d   = '0;
          tx_d    = STOP_LVL;
        end
      end
      S_STOP: begin
        if (Baud_Tick) begin
          if (cnt_q == STOP_LAST) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            tx_d    = IDLE_LVL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        tx_d    = IDLE_LVL;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      par_en_q <= 1'b0;
      par_q    <= PAR_EVEN;
      tx_q     <= IDLE_LVL;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      par_en_q <= par_en_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign TX_out = tx_q;
  assign Busy   = busy_q;
  assign Done   = done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: an 8N1 instance and a 7-bit/2-stop instance checked every cycle
// against a frame-as-bit-array model, plus literal expectations for known frames.
module tb_uart_tx_framer;
  import uart_tx_pkg::*;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       rst_n;
  logic [1:0] tick, dv, pen, ptyp;
  logic [7:0] pd8;
  logic [6:0] pd7;
  logic [1:0] tx_o, busy_o, done_o;

  int vectors    = 0;
  int miscompares = 0;

  logic [15:0] m_frame [2];
  int          m_len   [2];
  int          m_idx   [2];
  logic        m_busy  [2];
  logic        m_line  [2];
  logic        m_done  [2];

  uart_tx_framer #(.DATA_WIDTH(8), .STOP_BITS(1)) dut8 (
    .CLK(CLK), .RST(rst_n), .Baud_Tick(tick[0]), .P_DATA(pd8), .Data_Valid(dv[0]),
    .PAR_EN(pen[0]), .PAR_TYP(ptyp[0]), .TX_out(tx_o[0]), .Busy(busy_o[0]), .Done(done_o[0])
  );

  uart_tx_framer #(.DATA_WIDTH(7), .STOP_BITS(2)) dut7 (
    .CLK(CLK), .RST(rst_n), .Baud_Tick(tick[1]), .P_DATA(pd7), .Data_Valid(dv[1]),
    .PAR_EN(pen[1]), .PAR_TYP(ptyp[1]), .TX_out(tx_o[1]), .Busy(busy_o[1]), .Done(done_o[1])
  );

  // Bit i of the result is the line level during the i-th bit period of the frame.
  function automatic logic [15:0] frame_of(input int w, input logic [8:0] d,
                                           input logic pe, input logic pt);
    logic [15:0] f;
    int ones;
    f    = '1;
    f[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < w; i++) begin
      f[1+i] = d[i];
      ones += int'(d[i]);
    end
    if (pe) f[1+w] = logic'(ones % 2) ^ pt;
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      int w;
      int sb;
      logic [8:0] d;
      w  = (k == 0) ? 8 : 7;
      sb = (k == 0) ? 1 : 2;
      d  = (k == 0) ? {1'b0, pd8} : {2'b00, pd7};
      if (!rst_n) begin
        m_busy[k] = 1'b0;
        m_line[k] = 1'b1;
        m_done[k] = 1'b0;
      end else if (!m_busy[k]) begin
        m_done[k] = 1'b0;
        if (dv[k]) begin
          m_frame[k] = frame_of(w, d, pen[k], ptyp[k]);
          m_len[k]   = 1 + w + int'(pen[k]) + sb;
          m_idx[k]   = 0;
          m_busy[k]  = 1'b1;
          m_line[k]  = m_frame[k][0];
        end else begin
          m_line[k] = 1'b1;
        end
      end else begin
        m_done[k] = 1'b0;
        if (tick[k]) begin
          m_idx[k]++;
          if (m_idx[k] == m_len[k]) begin
            m_busy[k] = 1'b0;
            m_done[k] = 1'b1;
            m_line[k] = 1'b1;
          end else begin
            m_line[k] = m_frame[k][m_idx[k]];
          end
        end
      end
    end
  endtask

  // One clock: model follows the edge, DUT outputs compared on the falling edge.
  task automatic step();
    @(posedge CLK);
    model_update();
    @(negedge CLK);
    for (int k = 0; k < 2; k++)
      check($sformatf("dut%0d line/busy/done", k),
            32'({tx_o[k], busy_o[k], done_o[k]}),
            32'({m_line[k], m_busy[k], m_done[k]}));
  endtask

  task automatic set_data(input int k, input logic [8:0] d);
    if (k == 0) pd8 = d[7:0];
    else        pd7 = d[6:0];
  endtask

  // Sends one frame; samp[i] is the line level just before the i-th tick.
  task automatic run_frame(input int k, input logic [8:0] data, input logic pe, input logic pt,
                           input int period, input int glitch,
                           output logic [31:0] samp, output int nt, output int ndone);
    logic t;
    samp  = '1;
    nt    = 0;
    ndone = 0;
    set_data(k, data);
    pen[k]  = pe;
    ptyp[k] = pt;
    dv[k]   = 1'b1;
    tick[k] = 1'b0;
    step();
    dv[k] = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      t = (period > 0) ? logic'((c % period) == (period - 1)) : logic'($urandom_range(0, 2) == 0);
      if (c == glitch) begin
        dv[k] = 1'b1;
        set_data(k, 9'h000);
        pen[k]  = ~pe;
        ptyp[k] = ~pt;
      end else if (c == glitch + 1) begin
        dv[k] = 1'b0;
      end
      if (t && nt < 32) samp[nt] = tx_o[k];
      if (t) nt++;
      tick[k] = t;
      step();
      if (done_o[k]) begin
        ndone++;
        break;
      end
    end
    if (ndone == 0) check($sformatf("dut%0d frame completes", k), 32'd0, 32'd1);
    dv[k] = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick[k] = logic'(c % 2);
      step();
      if (done_o[k]) ndone++;
    end
    tick[k] = 1'b0;
  endtask

  initial begin
    logic [31:0] samp;
    logic [15:0] f;
    int nt, nd, zeros;
    logic dn, bz;

    rst_n = 1'b0;
    tick  = '0;
    dv    = '0;
    pen   = '0;
    ptyp  = '0;
    pd8   = '0;
    pd7   = '0;
    repeat (3) step();
    check("reset state dut8", 32'({tx_o[0], busy_o[0], done_o[0]}), 32'(3'b100));
    check("reset state dut7", 32'({tx_o[1], busy_o[1], done_o[1]}), 32'(3'b100));
    rst_n = 1'b1;
    step();

    f = frame_of(8, 9'h0A5, 1'b0, PAR_EVEN);
    check("model frame A5", 32'(f[9:0]), 32'h34A);
    f = frame_of(7, 9'h07F, 1'b1, PAR_ODD);
    check("model frame 7F odd", 32'(f[10:0]), 32'h6FE);

    run_frame(0, 9'h0A5, 1'b0, PAR_EVEN, 16, -1, samp, nt, nd);
    check("8N1 A5 line", 32'(samp[9:0]), 32'(10'b1101001010));
    check("8N1 A5 ticks", 32'(nt), 32'd10);
    check("8N1 A5 done pulses", 32'(nd), 32'd1);

    run_frame(0, 9'h003, 1'b1, PAR_EVEN, 0, -1, samp, nt, nd);
    check("even parity bit", 32'(samp[9]), 32'd0);
    check("even parity line", 32'(samp[10:0]), 32'h406);
    check("even parity ticks", 32'(nt), 32'd11);

    run_frame(0, 9'h003, 1'b1, PAR_ODD, 0, -1, samp, nt, nd);
    check("odd parity bit", 32'(samp[9]), 32'd1);
    check("odd parity ticks", 32'(nt), 32'd11);

    run_frame(1, 9'h07F, 1'b1, PAR_ODD, 16, -1, samp, nt, nd);
    check("7O2 parity bit", 32'(samp[8]), 32'd0);
    check("7O2 line", 32'(samp[10:0]), 32'h6FE);
    check("7O2 ticks", 32'(nt), 32'd11);

    run_frame(0, 9'h0FF, 1'b0, PAR_EVEN, 8, 30, samp, nt, nd);
    check("busy reject line", 32'(samp[9:0]), 32'h3FE);
    check("busy reject done pulses", 32'(nd), 32'd1);

    // Abort a frame in its data phase and confirm the line stays quiet afterwards.
    pd8   = 8'hC3;
    dv[0] = 1'b1;
    step();
    dv[0]   = 1'b0;
    tick[0] = 1'b1;
    repeat (3) step();
    rst_n   = 1'b0;
    tick[0] = 1'b0;
    step();
    check("mid-frame reset", 32'({tx_o[0], busy_o[0], done_o[0]}), 32'(3'b100));
    repeat (2) step();
    rst_n = 1'b1;
    zeros = 0;
    for (int c = 0; c < 40; c++) begin
      tick[0] = logic'($urandom_range(0, 1));
      step();
      if (tx_o[0] == 1'b0) zeros++;
    end
    check("line quiet after reset", 32'(zeros), 32'd0);

    pd8     = 8'h55;
    pen[0]  = 1'b0;
    dv[0]   = 1'b1;
    tick[0] = 1'b1;
    samp    = '0;
    dn      = 1'b0;
    bz      = 1'b0;
    for (int i = 0; i < 22; i++) begin
      step();
      samp[i] = tx_o[0];
      if (i == 10) dn = done_o[0];
      if (i == 11) bz = busy_o[0];
      if (i == 0)  pd8 = 8'hAA;
      if (i == 11) dv[0] = 1'b0;
    end
    tick[0] = 1'b0;
    check("back-to-back line", 32'(samp[21:0]), 32'h3AA6AA);
    check("back-to-back done", 32'(dn), 32'd1);
    check("back-to-back rebusy", 32'(bz), 32'd1);
    repeat (4) step();

    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      pd8   = 8'($urandom);
      pd7   = 7'($urandom);
      for (int k = 0; k < 2; k++) begin
        tick[k] = ($urandom_range(0, 3) == 0);
        dv[k]   = ($urandom_range(0, 5) == 0);
        pen[k]  = logic'($urandom_range(0, 1));
        ptyp[k] = logic'($urandom_range(0, 1));
      end
      step();
    end
    rst_n = 1'b1;
    dv    = '0;
    tick  = '0;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
